// File: rtl/iagc_pkg.sv
// Shared constants and types for the host serial link receive path.
// Holds the packet header, command codes and parser state encoding.
package iagc_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    localparam logic [7:0] CMD_SET_REF_AMPLITUDE = 8'h01;
    localparam logic [7:0] CMD_SET_GAIN          = 8'h02;
    localparam logic [7:0] CMD_FORCE_LOG         = 8'h03;

    typedef enum logic [2:0] {
        P_HDR,
        P_CMD,
        P_HI,
        P_LO,
        P_SUM
    } parser_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: input synchronizer, falling-edge start detect,
// mid-bit sampling and stop-bit validation.
module uart_rx
    import iagc_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 10,
    parameter int UART_DATA_SIZE = 8
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_rx,
    output logic [UART_DATA_SIZE-1:0] o_rxData,
    output logic                      o_rxValid,
    output logic                      o_frameError
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (UART_DATA_SIZE > 2) ? $clog2(UART_DATA_SIZE) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(UART_DATA_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_t;

    rx_state_t state, state_next;

    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic start_edge;

    logic [CW-1:0]             cnt, cnt_next;
    logic [BW-1:0]             bit_idx, bit_next;
    logic [UART_DATA_SIZE-1:0] shreg, shreg_next;
    logic [UART_DATA_SIZE-1:0] data_next;
    logic                      valid_next;
    logic                      ferr_next;

    // Synchronizer resets low so a line already low after reset
    // never looks like a start; only a later fall does.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta <= 1'b0;
            rx_sync <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            o_rxData     <= '0;
            o_rxValid    <= 1'b0;
            o_frameError <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            bit_idx      <= bit_next;
            shreg        <= shreg_next;
            o_rxData     <= data_next;
            o_rxValid    <= valid_next;
            o_frameError <= ferr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        bit_next   = bit_idx;
        shreg_next = shreg;
        data_next  = o_rxData;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                if (start_edge) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    state_next = rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {rx_sync, shreg[UART_DATA_SIZE-1:1]};
                    bit_next   = bit_idx + 1'b1;
                    if (bit_idx == DATA_LAST) begin
                        state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Leave at mid stop bit so the next start edge is not missed.
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                    if (rx_sync) begin
                        data_next  = shreg;
                        valid_next = 1'b1;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: byte receiver plus 5-byte packet parser
// (header, cmd, hi, lo, xor checksum) with inter-byte timeout.
module uart_cmd_rx #(
    parameter int         CLK_FREQUENCY  = 100_000_000,
    parameter int         UART_FREQUENCY = 9_200,
    parameter int         UART_DATA_SIZE = 8,
    parameter int         CMD_DATA_SIZE  = 16,
    parameter logic [7:0] HEADER_BYTE    = iagc_pkg::HEADER_BYTE,
    parameter int         TIMEOUT_BITS   = 40
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_rx,
    output logic [UART_DATA_SIZE-1:0] o_rxData,
    output logic                      o_rxValid,
    output logic [UART_DATA_SIZE-1:0] o_cmd,
    output logic [CMD_DATA_SIZE-1:0]  o_cmdData,
    output logic                      o_cmdValid,
    output logic                      o_frameError,
    output logic                      o_checksumError
);

    import iagc_pkg::*;

    localparam int CLKS_PER_BIT = CLK_FREQUENCY / UART_FREQUENCY;
    localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW           = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    uart_rx #(
        .CLKS_PER_BIT   (CLKS_PER_BIT),
        .UART_DATA_SIZE (UART_DATA_SIZE)
    ) u_rx (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx         (i_rx),
        .o_rxData     (o_rxData),
        .o_rxValid    (o_rxValid),
        .o_frameError (o_frameError)
    );

    parser_state_t p_state, p_next;

    logic [UART_DATA_SIZE-1:0] cmd_r, cmd_next;
    logic [UART_DATA_SIZE-1:0] hi_r, hi_next;
    logic [UART_DATA_SIZE-1:0] lo_r, lo_next;
    logic [TW-1:0]             tmo, tmo_next;
    logic [UART_DATA_SIZE-1:0] ocmd_next;
    logic [CMD_DATA_SIZE-1:0]  odata_next;
    logic                      cvalid_next;
    logic                      cerr_next;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            p_state         <= P_HDR;
            cmd_r           <= '0;
            hi_r            <= '0;
            lo_r            <= '0;
            tmo             <= '0;
            o_cmd           <= '0;
            o_cmdData       <= '0;
            o_cmdValid      <= 1'b0;
            o_checksumError <= 1'b0;
        end else begin
            p_state         <= p_next;
            cmd_r           <= cmd_next;
            hi_r            <= hi_next;
            lo_r            <= lo_next;
            tmo             <= tmo_next;
            o_cmd           <= ocmd_next;
            o_cmdData       <= odata_next;
            o_cmdValid      <= cvalid_next;
            o_checksumError <= cerr_next;
        end
    end

    always_comb begin
        p_next      = p_state;
        cmd_next    = cmd_r;
        hi_next     = hi_r;
        lo_next     = lo_r;
        ocmd_next   = o_cmd;
        odata_next  = o_cmdData;
        cvalid_next = 1'b0;
        cerr_next   = 1'b0;
        tmo_next    = tmo + 1'b1;
        if (p_state == P_HDR || o_rxValid) begin
            tmo_next = '0;
        end
        if (o_frameError) begin
            p_next = P_HDR;
        end else if (o_rxValid) begin
            unique case (p_state)
                P_HDR: begin
                    if (o_rxData == HEADER_BYTE) begin
                        p_next = P_CMD;
                    end
                end
                P_CMD: begin
                    cmd_next = o_rxData;
                    p_next   = P_HI;
                end
                P_HI: begin
                    hi_next = o_rxData;
                    p_next  = P_LO;
                end
                P_LO: begin
                    lo_next = o_rxData;
                    p_next  = P_SUM;
                end
                P_SUM: begin
                    p_next = P_HDR;
                    if (o_rxData == (cmd_r ^ hi_r ^ lo_r)) begin
                        ocmd_next   = cmd_r;
                        odata_next  = CMD_DATA_SIZE'({hi_r, lo_r});
                        cvalid_next = 1'b1;
                    end else begin
                        cerr_next = 1'b1;
                    end
                end
                default: begin
                    p_next = P_HDR;
                end
            endcase
        end else if (p_state != P_HDR && tmo == TMO_LAST) begin
            p_next   = P_HDR;
            tmo_next = '0;
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomized and directed bench for uart_cmd_rx against a packet-level
// reference model of the serial command protocol.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

    localparam int CLK_FREQUENCY  = 1_000_000;
    localparam int UART_FREQUENCY = 100_000;
    localparam int CPB            = CLK_FREQUENCY / UART_FREQUENCY;
    localparam logic [7:0] HDR    = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  cmd;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        frame_err;
    logic        chk_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rx_q[$];
    logic [23:0] cmd_q[$];
    int          ferr_n;
    int          chk_n;
    int          timing_n;
    logic        prev_valid = 1'b0;

    uart_cmd_rx #(
        .CLK_FREQUENCY  (CLK_FREQUENCY),
        .UART_FREQUENCY (UART_FREQUENCY),
        .UART_DATA_SIZE (8),
        .CMD_DATA_SIZE  (16),
        .HEADER_BYTE    (HDR),
        .TIMEOUT_BITS   (40)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_rx            (rx),
        .o_rxData        (rx_data),
        .o_rxValid       (rx_valid),
        .o_cmd           (cmd),
        .o_cmdData       (cmd_data),
        .o_cmdValid      (cmd_valid),
        .o_frameError    (frame_err),
        .o_checksumError (chk_err)
    );

    always #5 clk = ~clk;

    // Record pulses on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (cmd_valid) cmd_q.push_back({cmd, cmd_data});
        if (frame_err) ferr_n++;
        if (chk_err) chk_n++;
        if ((cmd_valid || chk_err) && !prev_valid) timing_n++;
        if (frame_err && rx_valid) timing_n++;
        prev_valid = rx_valid;
    end

    task automatic clear_mon();
        @(posedge clk);
        rx_q.delete();
        cmd_q.delete();
        ferr_n   = 0;
        chk_n    = 0;
        timing_n = 0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_list(input logic [7:0] bl[$]);
        foreach (bl[i]) send_byte(bl[i]);
        repeat (30) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx got %h/%b want 00/0", rx_data, rx_valid);
        end
        checks++;
        if (cmd !== 8'h00 || cmd_data !== 16'h0000 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmd got %h/%h/%b want 00/0000/0", cmd, cmd_data, cmd_valid);
        end
        checks++;
        if (frame_err !== 1'b0 || chk_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b/%b want 0/0", frame_err, chk_err);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] bl[$] = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h27};
        clear_mon();
        send_list(bl);
        checks++;
        if (rx_q.size() != 5 || rx_q != bl) begin
            errors++;
            $display("FAIL basic_bytes got %0d bytes want 5 matching", rx_q.size());
        end
        checks++;
        if (cmd_q.size() != 1) begin
            errors++;
            $display("FAIL basic_cmd_count got %0d want 1", cmd_q.size());
        end else if (cmd_q[0] !== 24'h011234) begin
            errors++;
            $display("FAIL basic_cmd got %h want 011234", cmd_q[0]);
        end
        checks++;
        if (timing_n != 0) begin
            errors++;
            $display("FAIL basic_timing got %0d want 0", timing_n);
        end
    endtask

    task automatic test_ignore();
        logic [7:0] bl[$] = '{8'h55, 8'hA5, 8'h02, 8'h00, 8'hFF, 8'hFD};
        clear_mon();
        send_list(bl);
        checks++;
        if (cmd_q.size() != 1 || cmd_q[0] !== 24'h0200FF) begin
            errors++;
            $display("FAIL ignore_cmd got n=%0d want one 0200FF", cmd_q.size());
        end
        checks++;
        if (rx_q.size() != 6) begin
            errors++;
            $display("FAIL ignore_bytes got %0d want 6", rx_q.size());
        end
    endtask

    task automatic test_checksum();
        logic [7:0] bl[$] = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h00};
        clear_mon();
        send_list(bl);
        checks++;
        if (chk_n != 1 || cmd_q.size() != 0) begin
            errors++;
            $display("FAIL chk_pulse got chk=%0d cmd=%0d want 1/0", chk_n, cmd_q.size());
        end
        checks++;
        if (cmd !== 8'h02 || cmd_data !== 16'h00FF) begin
            errors++;
            $display("FAIL chk_hold got %h/%h want 02/00FF", cmd, cmd_data);
        end
        checks++;
        if (timing_n != 0) begin
            errors++;
            $display("FAIL chk_timing got %0d want 0", timing_n);
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] good[$] = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h03};
        clear_mon();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12, 1'b0);
        repeat (20) @(negedge clk);
        checks++;
        if (ferr_n != 1 || rx_q.size() != 2) begin
            errors++;
            $display("FAIL ferr_pulse got ferr=%0d bytes=%0d want 1/2", ferr_n, rx_q.size());
        end
        send_list(good);
        checks++;
        if (cmd_q.size() != 1 || cmd_q[0] !== 24'h030000) begin
            errors++;
            $display("FAIL ferr_recover got n=%0d want one 030000", cmd_q.size());
        end
    endtask

    task automatic test_break();
        clear_mon();
        send_byte(8'h5A, 1'b0);
        rx = 1'b0;
        repeat (200) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (ferr_n != 1 || rx_q.size() != 0) begin
            errors++;
            $display("FAIL break got ferr=%0d bytes=%0d want 1/0", ferr_n, rx_q.size());
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (rx_q.size() != 0 || ferr_n != 0 || cmd_q.size() != 0 || chk_n != 0) begin
            errors++;
            $display("FAIL glitch got bytes=%0d ferr=%0d want 0/0", rx_q.size(), ferr_n);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] tail[$] = '{8'h12, 8'h34, 8'h27};
        logic [7:0] full[$] = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h27};
        clear_mon();
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (400) @(negedge clk);
        send_list(tail);
        checks++;
        if (cmd_q.size() != 0 || chk_n != 0 || rx_q.size() != 5) begin
            errors++;
            $display("FAIL timeout got cmd=%0d chk=%0d bytes=%0d want 0/0/5",
                     cmd_q.size(), chk_n, rx_q.size());
        end
        send_list(full);
        checks++;
        if (cmd_q.size() != 1) begin
            errors++;
            $display("FAIL timeout_recover got %0d want 1", cmd_q.size());
        end
    endtask

    task automatic test_random();
        logic [7:0]  sent[$];
        logic [23:0] exp_cmd[$];
        logic [7:0]  pk[4];
        logic [7:0]  b;
        int          exp_chk = 0;
        int          got = 0;
        clear_mon();
        for (int p = 0; p < 10; p++) begin
            logic [7:0] c  = 8'($urandom);
            logic [7:0] h  = 8'($urandom);
            logic [7:0] l  = 8'($urandom);
            logic [7:0] s  = c ^ h ^ l;
            if ($urandom_range(3) == 0) s = s ^ 8'($urandom_range(255, 1));
            if ($urandom_range(2) == 0) sent.push_back(8'($urandom));
            sent.push_back(HDR);
            sent.push_back(c);
            sent.push_back(h);
            sent.push_back(l);
            sent.push_back(s);
        end
        // Reference: count bytes collected after a header; the fifth closes it.
        for (int i = 0; i < sent.size(); i++) begin
            b = sent[i];
            if (got == 0) begin
                if (b == HDR) got = 1;
            end else begin
                pk[got-1] = b;
                got++;
                if (got == 5) begin
                    if (pk[3] == (pk[0] ^ pk[1] ^ pk[2])) exp_cmd.push_back({pk[0], pk[1], pk[2]});
                    else exp_chk++;
                    got = 0;
                end
            end
        end
        foreach (sent[i]) begin
            send_byte(sent[i]);
            repeat ($urandom_range(2) * CPB) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        checks++;
        if (rx_q != sent) begin
            errors++;
            $display("FAIL rand_bytes got %0d want %0d", rx_q.size(), sent.size());
        end
        checks++;
        if (cmd_q != exp_cmd) begin
            errors++;
            $display("FAIL rand_cmds got %0d want %0d", cmd_q.size(), exp_cmd.size());
        end
        checks++;
        if (chk_n != exp_chk || timing_n != 0) begin
            errors++;
            $display("FAIL rand_chk got %0d/%0d want %0d/0", chk_n, timing_n, exp_chk);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bl[$] = '{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64};
        send_byte(8'hA5);
        send_byte(8'h01);
        rx = 1'b0;
        repeat (25) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rx_data !== 8'h00 || cmd !== 8'h00 || cmd_data !== 16'h0000 ||
            rx_valid !== 1'b0 || cmd_valid !== 1'b0 ||
            frame_err !== 1'b0 || chk_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got %h/%h/%h want all 0", rx_data, cmd, cmd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        clear_mon();
        send_list(bl);
        checks++;
        if (rx_q.size() != 5 || cmd_q.size() != 1 || cmd_q[0] !== 24'h02ABCD) begin
            errors++;
            $display("FAIL reset_recover got bytes=%0d cmds=%0d want 5/1 02ABCD",
                     rx_q.size(), cmd_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        test_reset();
        test_basic();
        test_ignore();
        test_checksum();
        test_frame_error();
        test_break();
        test_glitch();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
